// File: rtl/bcd_scan_display.sv
// bcd_scan_display: four-digit BCD store with a time-multiplexed
// seven-segment scan, optional leading-zero blanking, a sticky
// invalid-digit flag and an end-of-frame pulse.
module bcd_scan_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bcd_in,
  input  logic        load,
  input  logic        clr,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] digits,
  output logic        err,
  output logic        frame
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [3:0]  d0, d1, d2, d3;
  logic [15:0] div_cnt;
  logic [1:0]  idx;
  logic        err_q;
  logic        blank_q;

  logic        dwell_end;
  logic        load_ok;
  logic [3:0]  cur_digit;
  logic [3:0]  lz_mask;
  logic        cur_blank;
  logic [6:0]  seg_raw;

  assign dwell_end = (div_cnt == DIV_LAST);
  assign load_ok   = (bcd_in <= 4'd9);

  // Scan timing: per-digit dwell counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (dwell_end) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Digit store and sticky error; clr has priority over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0    <= '0;
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      d0    <= '0;
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        d3 <= d2;
        d2 <= d1;
        d1 <= d0;
        d0 <= bcd_in;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  // Blanking enable is registered so seg depends on registered state only.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_lz;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_digit = d0;
    case (idx)
      2'd0: cur_digit = d0;
      2'd1: cur_digit = d1;
      2'd2: cur_digit = d2;
      2'd3: cur_digit = d3;
      default: cur_digit = d0;
    endcase
  end

  // Leading-zero mask: bit k set when dk and every higher digit are zero.
  // Bit 0 is never set so the units digit always shows.
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (d3 == 4'd0);
    lz_mask[2] = lz_mask[3] && (d2 == 4'd0);
    lz_mask[1] = lz_mask[2] && (d1 == 4'd0);
    lz_mask[0] = 1'b0;
  end

  assign cur_blank = blank_q && lz_mask[idx];

  // Seven-segment decode, {g,f,e,d,c,b,a}, active high.
  always_comb begin
    seg_raw = '0;
    case (cur_digit)
      4'd0: seg_raw = 7'h3F;
      4'd1: seg_raw = 7'h06;
      4'd2: seg_raw = 7'h5B;
      4'd3: seg_raw = 7'h4F;
      4'd4: seg_raw = 7'h66;
      4'd5: seg_raw = 7'h6D;
      4'd6: seg_raw = 7'h7D;
      4'd7: seg_raw = 7'h07;
      4'd8: seg_raw = 7'h7F;
      4'd9: seg_raw = 7'h6F;
      default: seg_raw = 7'h00;
    endcase
  end

  assign seg    = cur_blank ? 7'h00 : seg_raw;
  assign an     = 4'b0001 << idx;
  assign digits = {d3, d2, d1, d0};
  assign err    = err_q;
  assign frame  = (idx == 2'd3) && dwell_end;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed testbench for bcd_scan_display with SCAN_DIV=4.
module tb_bcd_scan_display;

  logic        clk;
  logic        rst;
  logic [3:0]  bcd_in;
  logic        load;
  logic        clr;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        err;
  logic        frame;

  int unsigned vectors;
  int unsigned miscompares;

  bcd_scan_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .load     (load),
    .clr      (clr),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .digits   (digits),
    .err      (err),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until an matches target, bounded to 20 cycles.
  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (an == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_digit(input logic [3:0] v);
    load   = 1'b1;
    bcd_in = v;
    tick();
    load   = 1'b0;
    bcd_in = 4'd0;
  endtask

  task automatic clear_store();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (an !== 4'b0001) begin miscompares++; $display("FAIL reset_an got=%b exp=0001", an); end
    vectors++;
    if (seg !== 7'h3F) begin miscompares++; $display("FAIL reset_seg got=%h exp=3f", seg); end
    vectors++;
    if (digits !== 16'h0000) begin miscompares++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
    vectors++;
    if (frame !== 1'b0) begin miscompares++; $display("FAIL reset_frame got=%b exp=0", frame); end
  endtask

  // Starts immediately after reset: div_cnt=0, idx=0.
  task automatic test_scan();
    logic [3:0] exp_an;
    logic       exp_frame;
    for (int c = 0; c < 32; c++) begin
      exp_an    = 4'b0001 << ((c / 4) % 4);
      exp_frame = ((c % 16) == 15);
      vectors++;
      if (an !== exp_an) begin
        miscompares++;
        $display("FAIL scan_an cycle=%0d got=%b exp=%b", c, an, exp_an);
      end
      vectors++;
      if (frame !== exp_frame) begin
        miscompares++;
        $display("FAIL scan_frame cycle=%0d got=%b exp=%b", c, frame, exp_frame);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_load();
    bit ok;
    load_digit(4'd1);
    load_digit(4'd2);
    load_digit(4'd3);
    load_digit(4'd4);
    vectors++;
    if (digits !== 16'h1234) begin miscompares++; $display("FAIL load_digits got=%h exp=1234", digits); end
    wait_an(4'b0001, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL load_wait_an0 got=%b exp=0001", an); end
    else begin
      vectors++;
      if (seg !== 7'h66) begin miscompares++; $display("FAIL load_seg_d0 got=%h exp=66", seg); end
    end
    wait_an(4'b1000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL load_wait_an3 got=%b exp=1000", an); end
    else begin
      vectors++;
      if (seg !== 7'h06) begin miscompares++; $display("FAIL load_seg_d3 got=%h exp=06", seg); end
    end
  endtask

  task automatic test_invalid_and_clear();
    load_digit(4'hA);
    vectors++;
    if (digits !== 16'h1234) begin miscompares++; $display("FAIL inval_digits got=%h exp=1234", digits); end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL inval_err got=%b exp=1", err); end
    tick();
    tick();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b exp=1", err); end
    clr    = 1'b1;
    load   = 1'b1;
    bcd_in = 4'd5;
    tick();
    clr    = 1'b0;
    load   = 1'b0;
    bcd_in = 4'd0;
    vectors++;
    if (digits !== 16'h0000) begin miscompares++; $display("FAIL clr_digits got=%h exp=0000", digits); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL clr_err got=%b exp=0", err); end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [3:0] tgt;
    logic [6:0] exp_seg;
    load_digit(4'd7);
    blank_lz = 1'b1;
    tick();
    vectors++;
    if (digits !== 16'h0007) begin miscompares++; $display("FAIL blank_digits got=%h exp=0007", digits); end
    for (int k = 3; k >= 0; k--) begin
      tgt     = 4'b0001 << k;
      exp_seg = (k == 0) ? 7'h07 : 7'h00;
      wait_an(tgt, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL blank_wait k=%0d got=%b exp=%b", k, an, tgt); end
      else if (seg !== exp_seg) begin
        miscompares++;
        $display("FAIL blank_0007 k=%0d got=%h exp=%h", k, seg, exp_seg);
      end
    end
    clear_store();
    load_digit(4'd5);
    load_digit(4'd0);
    load_digit(4'd7);
    vectors++;
    if (digits !== 16'h0507) begin miscompares++; $display("FAIL blank_digits2 got=%h exp=0507", digits); end
    wait_an(4'b0010, ok);
    vectors++;
    if (!ok || seg !== 7'h3F) begin miscompares++; $display("FAIL blank_inner_zero got=%h exp=3f", seg); end
    wait_an(4'b0100, ok);
    vectors++;
    if (!ok || seg !== 7'h6D) begin miscompares++; $display("FAIL blank_d2 got=%h exp=6d", seg); end
    wait_an(4'b1000, ok);
    vectors++;
    if (!ok || seg !== 7'h00) begin miscompares++; $display("FAIL blank_d3 got=%h exp=00", seg); end
    blank_lz = 1'b0;
    tick();
    wait_an(4'b1000, ok);
    vectors++;
    if (!ok || seg !== 7'h3F) begin miscompares++; $display("FAIL noblank_d3 got=%h exp=3f", seg); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [3:0] exp_an;
    clear_store();
    load_digit(4'd9);
    load_digit(4'd1);
    load_digit(4'd2);
    vectors++;
    if (digits !== 16'h0912) begin miscompares++; $display("FAIL mid_digits got=%h exp=0912", digits); end
    wait_an(4'b0100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL mid_wait got=%b exp=0100", an); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (digits !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_digits got=%h exp=0000", digits); end
    for (int c = 0; c < 5; c++) begin
      exp_an = (c < 4) ? 4'b0001 : 4'b0010;
      vectors++;
      if (an !== exp_an) begin
        miscompares++;
        $display("FAIL mid_rst_dwell cycle=%0d got=%b exp=%b", c, an, exp_an);
      end
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bcd_in      = 4'd0;
    load        = 1'b0;
    clr         = 1'b0;
    blank_lz    = 1'b0;
    #2;
    test_reset();
    test_scan();
    test_back_to_back_load();
    test_invalid_and_clear();
    test_blanking();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
